// File: rtl/vita49_seq.sv
// Sequencer driving vita49_pack/vita49_unpack ctrl+config words through reset, settle, run and flush phases.
// Latency: every output is registered and changes one cycle after the edge that samples the causing input.
// Backpressure: none applied; the unpack output handshake is only observed, and stalls there feed the timeout counter.
module vita49_seq #(
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int TO_W          = 24
) (
    input  logic            AXIS_ACLK,
    input  logic            AXIS_ARESET,
    input  logic            go,
    input  logic            abort,
    input  logic            cfg_mode,
    input  logic [31:0]     cfg_stream_id,
    input  logic [15:0]     cfg_pkt_size,
    input  logic [31:0]     cfg_words,
    input  logic [TO_W-1:0] cfg_timeout,
    input  logic            mon_tvalid,
    input  logic            mon_tready,
    output logic [31:0]     pack_ctrl,
    output logic [31:0]     unpack_ctrl,
    output logic [31:0]     pack_streamID,
    output logic [31:0]     unpack_streamID,
    output logic [15:0]     pack_pkt_size,
    output logic [31:0]     pack_words_to_pack,
    output logic [31:0]     unpack_words_to_unpack,
    output logic            busy,
    output logic            done,
    output logic            timeout,
    output logic [31:0]     beat_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_SETTLE,
        S_RUN,
        S_DONE,
        S_FLUSH
    } state_t;

    localparam logic [31:0] CTRL_IDLE = 32'h0;
    localparam logic [31:0] CTRL_RUN  = 32'h1;
    localparam logic [31:0] CTRL_RST  = 32'h2;
    localparam logic [31:0] CTRL_PASS = 32'h4;

    // Phase counters hold the index of the current cycle within RST/SETTLE/FLUSH.
    localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    state_t          state;
    logic [31:0]     ctrl_q;
    logic [31:0]     stream_id_q;
    logic [31:0]     words_q;
    logic [TO_W-1:0] to_lim_q;
    logic            mode_q;
    logic [15:0]     phase_cnt;
    logic [TO_W-1:0] to_cnt;

    logic            hs;
    logic [31:0]     beat_inc;
    logic [TO_W-1:0] to_inc;

    // Both blocks always receive the same command and stream configuration.
    assign pack_ctrl              = ctrl_q;
    assign unpack_ctrl            = ctrl_q;
    assign pack_streamID          = stream_id_q;
    assign unpack_streamID        = stream_id_q;
    assign pack_words_to_pack     = words_q;
    assign unpack_words_to_unpack = words_q;

    // Handshake detect, saturating beat increment and idle-gap increment.
    always_comb begin
        hs       = mon_tvalid & mon_tready;
        beat_inc = (beat_count == 32'hFFFF_FFFF) ? beat_count : beat_count + 32'd1;
        to_inc   = to_cnt + TO_W'(1);
    end

    // Sequencer FSM; outputs are written together with the state they belong to.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state         <= S_IDLE;
            ctrl_q        <= CTRL_IDLE;
            stream_id_q   <= 32'h0;
            pack_pkt_size <= 16'h0;
            words_q       <= 32'h0;
            to_lim_q      <= '0;
            mode_q        <= 1'b0;
            phase_cnt     <= 16'h0;
            to_cnt        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            beat_count    <= 32'h0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // abort alongside go drops the go.
                    if (go && !abort) begin
                        stream_id_q   <= cfg_stream_id;
                        pack_pkt_size <= cfg_pkt_size;
                        words_q       <= cfg_words;
                        to_lim_q      <= cfg_timeout;
                        mode_q        <= cfg_mode;
                        beat_count    <= 32'h0;
                        done          <= 1'b0;
                        timeout       <= 1'b0;
                        phase_cnt     <= 16'h0;
                        to_cnt        <= '0;
                        ctrl_q        <= CTRL_RST;
                        busy          <= 1'b1;
                        state         <= S_RST;
                    end
                end
                S_RST: begin
                    if (abort) begin
                        phase_cnt <= 16'h0;
                        ctrl_q    <= CTRL_RST;
                        state     <= S_FLUSH;
                    end else if (phase_cnt == RST_LAST) begin
                        phase_cnt <= 16'h0;
                        ctrl_q    <= CTRL_IDLE;
                        state     <= S_SETTLE;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        phase_cnt <= 16'h0;
                        ctrl_q    <= CTRL_RST;
                        state     <= S_FLUSH;
                    end else if (phase_cnt == SETTLE_LAST) begin
                        phase_cnt <= 16'h0;
                        to_cnt    <= '0;
                        ctrl_q    <= mode_q ? CTRL_PASS : CTRL_RUN;
                        state     <= S_RUN;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        phase_cnt <= 16'h0;
                        ctrl_q    <= CTRL_RST;
                        state     <= S_FLUSH;
                    end else if (words_q == 32'h0) begin
                        // Nothing to move: finish after a single RUN cycle.
                        ctrl_q <= CTRL_IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else if (hs) begin
                        // A beat in the same cycle as the timeout limit keeps the run alive.
                        beat_count <= beat_inc;
                        to_cnt     <= '0;
                        if (beat_inc == words_q) begin
                            ctrl_q <= CTRL_IDLE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end
                    end else if ((to_lim_q != '0) && (to_inc == to_lim_q)) begin
                        timeout   <= 1'b1;
                        phase_cnt <= 16'h0;
                        ctrl_q    <= CTRL_RST;
                        state     <= S_FLUSH;
                    end else begin
                        to_cnt <= to_inc;
                    end
                end
                S_FLUSH: begin
                    if (phase_cnt == RST_LAST) begin
                        phase_cnt <= 16'h0;
                        ctrl_q    <= CTRL_IDLE;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                default: begin
                    ctrl_q <= CTRL_IDLE;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
